// File: rtl/pwm_sysid_pkg.sv
// pwm_sysid_pkg: shared state encoding, bus addresses and data width for the system-ID checker
package pwm_sysid_pkg;
  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, PASS, FAIL} sysid_state_t;
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  localparam int SYSID_DATA_W = 32;
endpackage

// File: rtl/pwm_sysid_timeout.sv
// pwm_sysid_timeout: stall counter that flags a read stalled for TIMEOUT_CYCLES cycles
module pwm_sysid_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  assign expired = cnt_q == TMAX;
  assign cnt_d = clear ? '0 : (enable && !expired) ? cnt_q + 1'b1 : cnt_q;
  // count stalled cycles, saturating at the limit until the next clear
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pwm_control_core_sysid_checker.sv
// pwm_control_core_sysid_checker: reads system ID/timestamp, gates PWM enable; SYSID_CHECK_TIMESTAMP_EN adds the timestamp to the match
module pwm_control_core_sysid_checker
  import pwm_sysid_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID = 32'h2013_1107,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_TS = 32'h53A9_2627,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RETRY_MAX = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    avm_address,
  output logic                    avm_read,
  input  logic                    avm_waitrequest,
  input  logic [SYSID_DATA_W-1:0] avm_readdata,
  output logic [SYSID_DATA_W-1:0] id_value,
  output logic [SYSID_DATA_W-1:0] ts_value,
  output logic                    busy,
  output logic                    done,
  output logic                    id_ok,
  output logic                    timeout,
  output logic                    pwm_enable
);
`ifdef SYSID_CHECK_TIMESTAMP_EN
  localparam logic TS_EN = 1'b1;
`else
  localparam logic TS_EN = 1'b0;
`endif
  localparam logic [4:0] RMAX = 5'(RETRY_MAX);
  sysid_state_t state_q, state_d;
  logic read_q, read_d, to_q, to_d, pwm_q, pwm_d;
  logic [4:0] retry_q, retry_d;
  logic [SYSID_DATA_W-1:0] id_q, id_d, ts_q, ts_d;
  logic expired, accept, match, restart;
  assign accept = read_q && !avm_waitrequest;
  assign match = id_q == EXPECTED_ID && (!TS_EN || ts_q == EXPECTED_TS);
  assign restart = start && (state_q == PASS || state_q == FAIL);
  assign avm_read = read_q;
  assign avm_address = state_q == RD_TS ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign id_value = id_q;
  assign ts_value = ts_q;
  assign busy = state_q == RD_ID || state_q == RD_TS || state_q == CHECK;
  assign done = state_q == PASS || state_q == FAIL;
  assign id_ok = state_q == PASS;
  assign timeout = to_q;
  assign pwm_enable = pwm_q;
  assign pwm_d = id_ok && !restart;
  // every read is preceded by a cycle with read low, which doubles as the counter clear
  pwm_sysid_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (!read_q),
    .enable (read_q && avm_waitrequest),
    .expired(expired)
  );
  // sequence control: issue reads, capture data, retry on stall, compare
  always_comb begin
    state_d = state_q;
    read_d = read_q;
    retry_d = retry_q;
    to_d = to_q;
    id_d = id_q;
    ts_d = ts_q;
    case (state_q)
      IDLE: state_d = RD_ID;
      RD_ID, RD_TS: begin
        if (!read_q) read_d = 1'b1;
        else if (accept) begin
          read_d = 1'b0;
          id_d = state_q == RD_ID ? avm_readdata : id_q;
          ts_d = state_q == RD_TS ? avm_readdata : ts_q;
          state_d = state_q == RD_ID ? RD_TS : CHECK;
        end else if (expired) begin
          read_d = 1'b0;
          retry_d = retry_q + 5'd1;
          to_d = retry_d > RMAX;
          state_d = retry_d > RMAX ? FAIL : RD_ID;
        end
      end
      CHECK: state_d = match ? PASS : FAIL;
      PASS, FAIL: begin
        state_d = start ? RD_ID : state_q;
        retry_d = start ? 5'd0 : retry_q;
        to_d = start ? 1'b0 : to_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      read_q <= 1'b0;
      retry_q <= '0;
      to_q <= 1'b0;
      id_q <= '0;
      ts_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      read_q <= read_d;
      retry_q <= retry_d;
      to_q <= to_d;
      id_q <= id_d;
      ts_q <= ts_d;
      pwm_q <= pwm_d;
    end
  end
endmodule

// File: tb/tb_pwm_control_core_sysid_checker.sv
// tb_pwm_control_core_sysid_checker: randomized bench against a transaction-level model of the ID check
module tb_pwm_control_core_sysid_checker;
  localparam int T = 4;
  localparam int RM = 2;
  localparam logic [31:0] EID = 32'h2013_1107;
  localparam logic [31:0] ETS = 32'h53A9_2627;
`ifdef SYSID_CHECK_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic avm_address, avm_read, busy, done, id_ok, timeout, pwm_enable;
  logic [31:0] id_value, ts_value;
  int n_chk = 0, n_pass = 0;
  logic [31:0] id_word, ts_word, exp_id = '0, exp_ts = '0;
  int stalls[8];
  int req_n = 0, left = 0;
  bit in_req = 0;

  pwm_control_core_sysid_checker #(.TIMEOUT_CYCLES(T), .RETRY_MAX(RM)) dut (
    .clock(clock), .reset(reset), .start(start), .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata), .id_value(id_value),
    .ts_value(ts_value), .busy(busy), .done(done), .id_ok(id_ok), .timeout(timeout),
    .pwm_enable(pwm_enable)
  );

  always #5 clock = ~clock;

  // slave: each new request stalls for its listed cycle count, then returns the word at its address
  always @(negedge clock) begin
    if (reset || !avm_read) begin
      in_req = 0;
      avm_waitrequest = 0;
    end else begin
      if (!in_req) begin
        in_req = 1;
        left = req_n < 8 ? stalls[req_n] : 0;
        req_n++;
      end
      avm_waitrequest = left > 0;
      if (left > 0) left--;
      avm_readdata = avm_address ? ts_word : id_word;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // a read accepted after s stalls costs 1 idle + s+1 cycles; a timed-out one 1 + T+1
  task automatic model(output int cyc, output int reads, output bit pass, output bit to);
    int retries, s;
    bit on_ts, fin;
    retries = 0; on_ts = 0; fin = 0; cyc = 1; reads = 0; pass = 0; to = 0;
    while (!fin) begin
      s = stalls[reads];
      reads++;
      cyc += 1;
      if (s <= T) begin
        cyc += s + 1;
        if (!on_ts) begin
          exp_id = id_word;
          on_ts = 1;
        end else begin
          exp_ts = ts_word;
          cyc += 1;
          pass = exp_id == EID && (!TS_EN || exp_ts == ETS);
          fin = 1;
        end
      end else begin
        cyc += T + 1;
        retries++;
        on_ts = 0;
        if (retries > RM) begin
          to = 1;
          fin = 1;
        end
      end
    end
  endtask

  task automatic wait_done(input int already, input int cyc, input bit pass, input bit to, input int reads);
    int n;
    n = already;
    while (!done && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("cycles", 32'(n), 32'(cyc));
    check("done", 32'(done), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("id_ok", 32'(id_ok), 32'(pass));
    check("timeout", 32'(timeout), 32'(to));
    check("id_value", id_value, exp_id);
    check("ts_value", ts_value, exp_ts);
    check("pwm_lag", 32'(pwm_enable), 32'd0);
    check("reads", 32'(req_n), 32'(reads));
    @(negedge clock);
    check("pwm_enable", 32'(pwm_enable), 32'(pass));
  endtask

  task automatic run_case(input bit via_start);
    int cyc, reads;
    bit pass, to;
    req_n = 0;
    if (via_start) begin
      model(cyc, reads, pass, to);
      start = 1;
      @(negedge clock);
      start = 0;
      check("start_pwm_drop", 32'(pwm_enable), 32'd0);
      check("start_done_clr", 32'(done), 32'd0);
      check("start_busy", 32'(busy), 32'd1);
      wait_done(1, cyc, pass, to, reads);
    end else begin
      reset = 1;
      @(negedge clock);
      @(negedge clock);
      exp_id = '0;
      exp_ts = '0;
      model(cyc, reads, pass, to);
      reset = 0;
      wait_done(0, cyc, pass, to, reads);
    end
  endtask

  task automatic set_case(input logic [31:0] i, input logic [31:0] t, input int s0, input int s1, input int rest);
    id_word = i;
    ts_word = t;
    stalls[0] = s0;
    stalls[1] = s1;
    for (int k = 2; k < 8; k++) stalls[k] = rest;
  endtask

  initial begin
    int n;
    set_case(EID, ETS, 0, 0, 0);
    repeat (3) @(negedge clock);
    check("rst_read", 32'(avm_read), 32'd0);
    check("rst_addr", 32'(avm_address), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_idok", 32'(id_ok), 32'd0);
    check("rst_to", 32'(timeout), 32'd0);
    check("rst_pwm", 32'(pwm_enable), 32'd0);
    check("rst_id", id_value, 32'd0);
    check("rst_ts", ts_value, 32'd0);
    run_case(0);
    set_case(32'h2013_1108, ETS, 0, 0, 0);
    run_case(0);
    set_case(EID, 32'h53A9_2628, 0, 0, 0);
    run_case(0);
    set_case(EID, ETS, 100, 100, 100);
    run_case(0);
    set_case(EID, ETS, 4, 0, 0);
    run_case(0);
    set_case(EID, ETS, 2, 3, 0);
    run_case(1);
    run_case(1);
    set_case(EID, ETS, 0, 0, 0);
    req_n = 0;
    reset = 1;
    @(negedge clock);
    reset = 0;
    n = 0;
    while (!(avm_read && avm_address) && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("reach_rd_ts", 32'(avm_read && avm_address), 32'd1);
    reset = 1;
    @(negedge clock);
    check("mid_rst_read", 32'(avm_read), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_id", id_value, 32'd0);
    check("mid_rst_ts", ts_value, 32'd0);
    exp_id = '0;
    exp_ts = '0;
    req_n = 0;
    reset = 0;
    @(negedge clock);
    @(negedge clock);
    start = 1;
    @(negedge clock);
    start = 0;
    check("busy_start_ign", 32'(busy), 32'd1);
    exp_id = EID;
    exp_ts = ETS;
    wait_done(3, 6, 1, 0, 2);
    for (int r = 0; r < 24; r++) begin
      id_word = $urandom_range(0, 1) ? EID : EID ^ (32'd1 << $urandom_range(0, 31));
      ts_word = $urandom_range(0, 1) ? ETS : ETS ^ (32'd1 << $urandom_range(0, 31));
      for (int k = 0; k < 8; k++)
        stalls[k] = $urandom_range(0, 3) == 0 ? int'($urandom_range(T + 1, T + 3)) : int'($urandom_range(0, T));
      run_case(bit'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
